// File: rtl/branch_resolve.sv
// EX-stage conditional branch resolution: evaluates the branch held in the EX
// register, flags mispredictions, supplies the redirect PC and keeps statistics.
module branch_resolve (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        btype_ID,
  input  logic [2:0]  funct3_ID,
  input  logic [31:0] pc_ID,
  input  logic [31:0] imm_ID,
  input  logic        predict_ID,
  input  logic [31:0] rs1_EX,
  input  logic [31:0] rs2_EX,
  output logic        branch_valid_EX,
  output logic        branch_result_EX,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispredict_cnt
);

  logic        valid_r;
  logic [2:0]  funct3_r;
  logic        predict_r;
  logic [31:0] target_r;
  logic [31:0] fallthrough_r;
  logic [15:0] branch_cnt_r;
  logic [15:0] mispredict_cnt_r;

  logic        result_s;
  logic        mispredict_s;
  logic [31:0] redirect_s;

  function automatic logic branch_taken(input logic [2:0]  funct3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic taken;
    case (funct3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) < $signed(b));
      3'b101:  taken = ($signed(a) >= $signed(b));
      3'b110:  taken = (a < b);
      3'b111:  taken = (a >= b);
      default: taken = 1'b0;  // 010/011 are not branch encodings
    endcase
    return taken;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  // Resolve the EX branch against forwarded operands in the same cycle
  always_comb begin
    result_s     = 1'b0;
    mispredict_s = 1'b0;
    redirect_s   = 32'h0000_0000;
    if (valid_r) begin
      result_s     = branch_taken(funct3_r, rs1_EX, rs2_EX);
      mispredict_s = (result_s != predict_r);
      if (result_s) begin
        redirect_s = target_r;
      end else begin
        redirect_s = fallthrough_r;
      end
    end else begin
      result_s     = 1'b0;
      mispredict_s = 1'b0;
      redirect_s   = 32'h0000_0000;
    end
  end

  // EX register and statistics counters; a flush overrides the ID load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r          <= 1'b0;
      funct3_r         <= 3'b000;
      predict_r        <= 1'b0;
      target_r         <= 32'h0000_0000;
      fallthrough_r    <= 32'h0000_0000;
      branch_cnt_r     <= 16'h0000;
      mispredict_cnt_r <= 16'h0000;
    end else if (!stall) begin
      if (valid_r) begin
        branch_cnt_r <= sat_inc(branch_cnt_r);
      end
      if (mispredict_s) begin
        mispredict_cnt_r <= sat_inc(mispredict_cnt_r);
        valid_r          <= 1'b0;
      end else begin
        valid_r       <= btype_ID;
        funct3_r      <= funct3_ID;
        predict_r     <= predict_ID;
        target_r      <= pc_ID + imm_ID;
        fallthrough_r <= pc_ID + 32'd4;
      end
    end
  end

  assign branch_valid_EX  = valid_r;
  assign branch_result_EX = result_s;
  assign mispredict       = mispredict_s;
  assign redirect_pc      = redirect_s;
  assign branch_cnt       = branch_cnt_r;
  assign mispredict_cnt   = mispredict_cnt_r;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus randomized
// traffic compared against a behavioural model of the EX branch slot.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        btype_ID;
  logic [2:0]  funct3_ID;
  logic [31:0] pc_ID;
  logic [31:0] imm_ID;
  logic        predict_ID;
  logic [31:0] rs1_EX;
  logic [31:0] rs2_EX;
  logic        branch_valid_EX;
  logic        branch_result_EX;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  // Model of the branch sitting in EX: raw PC/immediate kept, target derived on use
  bit        m_valid;
  bit [2:0]  m_f3;
  bit        m_pred;
  bit [31:0] m_pc;
  bit [31:0] m_imm;
  int        m_bcnt;
  int        m_mcnt;

  branch_resolve dut (
    .clk(clk), .reset(reset), .stall(stall), .btype_ID(btype_ID),
    .funct3_ID(funct3_ID), .pc_ID(pc_ID), .imm_ID(imm_ID), .predict_ID(predict_ID),
    .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .branch_valid_EX(branch_valid_EX),
    .branch_result_EX(branch_result_EX), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit rule_taken(bit [2:0] f3, bit [31:0] a, bit [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    if (f3 == 3'd0) return ua == ub;
    if (f3 == 3'd1) return ua != ub;
    if (f3 == 3'd4) return sa < sb;
    if (f3 == 3'd5) return sa >= sb;
    if (f3 == 3'd6) return ua < ub;
    if (f3 == 3'd7) return ua >= ub;
    return 1'b0;
  endfunction

  function automatic bit exp_result();
    return m_valid && rule_taken(m_f3, rs1_EX, rs2_EX);
  endfunction

  function automatic bit exp_mis();
    return m_valid && (exp_result() != m_pred);
  endfunction

  function automatic bit [31:0] exp_redirect();
    bit [31:0] t;
    if (!m_valid) return 32'h0;
    t = exp_result() ? m_pc + m_imm : m_pc + 32'd4;
    return t;
  endfunction

  function automatic void model_clear();
    m_valid = 1'b0; m_f3 = 3'd0; m_pred = 1'b0; m_pc = 32'h0; m_imm = 32'h0;
    m_bcnt = 0; m_mcnt = 0;
  endfunction

  task automatic drive(input logic s, input logic b, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm, input logic p,
                       input logic [31:0] a, input logic [31:0] bb);
    stall = s; btype_ID = b; funct3_ID = f3; pc_ID = pc; imm_ID = imm;
    predict_ID = p; rs1_EX = a; rs2_EX = bb;
    #1;
  endtask

  // Advance one clock and apply the architectural rules to the model
  task automatic tick();
    bit mis;
    @(posedge clk);
    if (reset && !stall) begin
      mis = exp_mis();
      if (m_valid) m_bcnt = (m_bcnt >= 65535) ? 65535 : m_bcnt + 1;
      if (mis) m_mcnt = (m_mcnt >= 65535) ? 65535 : m_mcnt + 1;
      if (mis) m_valid = 1'b0;
      else begin
        m_valid = btype_ID; m_f3 = funct3_ID; m_pred = predict_ID;
        m_pc = pc_ID; m_imm = imm_ID;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    drive(1'b0, 1'b1, 3'd0, 32'h40, 32'h8, 1'b0, 32'h1, 32'h1);
    checks += 6;
    if (branch_valid_EX !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", branch_valid_EX); end
    if (branch_result_EX !== 1'b0) begin errors++; $display("FAIL reset_result got %b want 0", branch_result_EX); end
    if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mis got %b want 0", mispredict); end
    if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got %h want 0", redirect_pc); end
    if (branch_cnt !== 16'h0) begin errors++; $display("FAIL reset_bcnt got %h want 0", branch_cnt); end
    if (mispredict_cnt !== 16'h0) begin errors++; $display("FAIL reset_mcnt got %h want 0", mispredict_cnt); end
    tick();
    checks++;
    if (branch_valid_EX !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got %b want 0", branch_valid_EX); end
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_beq_mispredict();
    drive(1'b0, 1'b1, 3'b000, 32'h100, 32'h20, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'd5, 32'd5);
    checks += 4;
    if (branch_valid_EX !== 1'b1) begin errors++; $display("FAIL beq_valid got %b want 1", branch_valid_EX); end
    if (branch_result_EX !== 1'b1) begin errors++; $display("FAIL beq_result got %b want 1", branch_result_EX); end
    if (mispredict !== 1'b1) begin errors++; $display("FAIL beq_mis got %b want 1", mispredict); end
    if (redirect_pc !== 32'h120) begin errors++; $display("FAIL beq_redirect got %h want 120", redirect_pc); end
    tick();
    checks += 3;
    if (mispredict_cnt !== 16'd1) begin errors++; $display("FAIL beq_mcnt got %h want 1", mispredict_cnt); end
    if (branch_cnt !== 16'd1) begin errors++; $display("FAIL beq_bcnt got %h want 1", branch_cnt); end
    if (branch_valid_EX !== 1'b0) begin errors++; $display("FAIL beq_bubble got %b want 0", branch_valid_EX); end
  endtask

  task automatic test_blt_bltu();
    drive(1'b0, 1'b1, 3'b100, 32'h200, 32'hFFFF_FFF0, 1'b1, 32'h0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 3'b110, 32'h200, 32'hFFFF_FFF0, 1'b1, 32'hFFFF_FFFF, 32'd1);
    checks += 3;
    if (branch_result_EX !== 1'b1) begin errors++; $display("FAIL blt_result got %b want 1", branch_result_EX); end
    if (mispredict !== 1'b0) begin errors++; $display("FAIL blt_mis got %b want 0", mispredict); end
    if (redirect_pc !== 32'h1F0) begin errors++; $display("FAIL blt_redirect got %h want 1f0", redirect_pc); end
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    checks += 3;
    if (branch_result_EX !== 1'b0) begin errors++; $display("FAIL bltu_result got %b want 0", branch_result_EX); end
    if (mispredict !== 1'b1) begin errors++; $display("FAIL bltu_mis got %b want 1", mispredict); end
    if (redirect_pc !== 32'h204) begin errors++; $display("FAIL bltu_redirect got %h want 204", redirect_pc); end
    tick();
    checks += 2;
    if (branch_cnt !== 16'd3) begin errors++; $display("FAIL bltu_bcnt got %h want 3", branch_cnt); end
    if (mispredict_cnt !== 16'd2) begin errors++; $display("FAIL bltu_mcnt got %h want 2", mispredict_cnt); end
  endtask

  task automatic test_flush_priority();
    int b0;
    drive(1'b0, 1'b1, 3'b001, 32'h300, 32'h40, 1'b1, 32'h0, 32'h0);
    tick();
    b0 = m_bcnt;
    drive(1'b0, 1'b1, 3'b000, 32'h304, 32'h10, 1'b1, 32'd9, 32'd9);
    checks++;
    if (mispredict !== 1'b1) begin errors++; $display("FAIL flush_mis got %b want 1", mispredict); end
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
    checks += 2;
    if (branch_valid_EX !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", branch_valid_EX); end
    if (branch_cnt !== 16'(b0 + 1)) begin errors++; $display("FAIL flush_bcnt got %h want %h", branch_cnt, 16'(b0 + 1)); end
    tick();
    checks++;
    if (branch_cnt !== 16'(b0 + 1)) begin errors++; $display("FAIL flush_bcnt2 got %h want %h", branch_cnt, 16'(b0 + 1)); end
  endtask

  task automatic test_stall_hold();
    int b0;
    int m0;
    drive(1'b0, 1'b1, 3'b000, 32'h400, 32'h80, 1'b1, 32'h0, 32'h0);
    tick();
    b0 = m_bcnt; m0 = m_mcnt;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 3'b000, 32'h500, 32'h4, 1'b0, 32'd1, 32'd2);
      checks += 4;
      if (mispredict !== 1'b1) begin errors++; $display("FAIL stall_mis[%0d] got %b want 1", i, mispredict); end
      if (redirect_pc !== 32'h404) begin errors++; $display("FAIL stall_redirect[%0d] got %h want 404", i, redirect_pc); end
      if (mispredict_cnt !== 16'(m0)) begin errors++; $display("FAIL stall_mcnt[%0d] got %h want %h", i, mispredict_cnt, 16'(m0)); end
      if (branch_cnt !== 16'(b0)) begin errors++; $display("FAIL stall_bcnt[%0d] got %h want %h", i, branch_cnt, 16'(b0)); end
      tick();
    end
    drive(1'b0, 1'b1, 3'b000, 32'h500, 32'h4, 1'b0, 32'd1, 32'd2);
    checks++;
    if (mispredict !== 1'b1) begin errors++; $display("FAIL stall_release_mis got %b want 1", mispredict); end
    tick();
    checks += 3;
    if (mispredict_cnt !== 16'(m0 + 1)) begin errors++; $display("FAIL stall_final_mcnt got %h want %h", mispredict_cnt, 16'(m0 + 1)); end
    if (branch_cnt !== 16'(b0 + 1)) begin errors++; $display("FAIL stall_final_bcnt got %h want %h", branch_cnt, 16'(b0 + 1)); end
    if (branch_valid_EX !== 1'b0) begin errors++; $display("FAIL stall_final_valid got %b want 0", branch_valid_EX); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      case ($urandom_range(3, 0))
        0: b = a;
        1: b = a ^ 32'h8000_0000;
        2: b = a + 32'($urandom_range(2, 0)) - 32'd1;
        default: b = $urandom;
      endcase
      drive(($urandom_range(4, 0) == 0), ($urandom_range(3, 0) != 0), 3'($urandom_range(7, 0)),
            $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom_range(1, 0)), a, b);
      checks += 6;
      if (branch_valid_EX !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", i, branch_valid_EX, m_valid); end
      if (branch_result_EX !== exp_result()) begin errors++; $display("FAIL rnd_result[%0d] got %b want %b", i, branch_result_EX, exp_result()); end
      if (mispredict !== exp_mis()) begin errors++; $display("FAIL rnd_mis[%0d] got %b want %b", i, mispredict, exp_mis()); end
      if (redirect_pc !== exp_redirect()) begin errors++; $display("FAIL rnd_redirect[%0d] got %h want %h", i, redirect_pc, exp_redirect()); end
      if (branch_cnt !== 16'(m_bcnt)) begin errors++; $display("FAIL rnd_bcnt[%0d] got %h want %h", i, branch_cnt, 16'(m_bcnt)); end
      if (mispredict_cnt !== 16'(m_mcnt)) begin errors++; $display("FAIL rnd_mcnt[%0d] got %h want %h", i, mispredict_cnt, 16'(m_mcnt)); end
      tick();
    end
  endtask

  task automatic test_saturation();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    force dut.branch_cnt_r = 16'hFFFE;
    force dut.mispredict_cnt_r = 16'hFFFE;
    #1;
    release dut.branch_cnt_r;
    release dut.mispredict_cnt_r;
    m_bcnt = 65534; m_mcnt = 65534;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 3'b000, 32'h600, 32'h10, 1'b0, 32'h0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'd7, 32'd7);
      checks++;
      if (mispredict !== 1'b1) begin errors++; $display("FAIL sat_mis[%0d] got %b want 1", i, mispredict); end
      tick();
    end
    checks += 2;
    if (branch_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_bcnt got %h want ffff", branch_cnt); end
    if (mispredict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_mcnt got %h want ffff", mispredict_cnt); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 3'b000, 32'h700, 32'h20, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 3'b000, 32'h0, 32'h0, 1'b0, 32'd3, 32'd3);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    checks += 6;
    if (branch_valid_EX !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", branch_valid_EX); end
    if (branch_result_EX !== 1'b0) begin errors++; $display("FAIL arst_result got %b want 0", branch_result_EX); end
    if (mispredict !== 1'b0) begin errors++; $display("FAIL arst_mis got %b want 0", mispredict); end
    if (redirect_pc !== 32'h0) begin errors++; $display("FAIL arst_redirect got %h want 0", redirect_pc); end
    if (branch_cnt !== 16'h0) begin errors++; $display("FAIL arst_bcnt got %h want 0", branch_cnt); end
    if (mispredict_cnt !== 16'h0) begin errors++; $display("FAIL arst_mcnt got %h want 0", mispredict_cnt); end
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b1, 3'b010, 32'h800, 32'h40, 1'b0, 32'd3, 32'd3);
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'd3, 32'd3);
    checks += 4;
    if (branch_valid_EX !== 1'b1) begin errors++; $display("FAIL f010_valid got %b want 1", branch_valid_EX); end
    if (branch_result_EX !== 1'b0) begin errors++; $display("FAIL f010_result got %b want 0", branch_result_EX); end
    if (mispredict !== 1'b0) begin errors++; $display("FAIL f010_mis got %b want 0", mispredict); end
    if (redirect_pc !== 32'h804) begin errors++; $display("FAIL f010_redirect got %h want 804", redirect_pc); end
    tick();
    checks += 2;
    if (branch_cnt !== 16'd1) begin errors++; $display("FAIL f010_bcnt got %h want 1", branch_cnt); end
    if (mispredict_cnt !== 16'd0) begin errors++; $display("FAIL f010_mcnt got %h want 0", mispredict_cnt); end
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_blt_bltu();
    test_flush_priority();
    test_stall_hold();
    test_random();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
